pipe_sequencer: RTL and testbench

PIPE_SEQUENCER -- requirements
Module: pipe_sequencer

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipe_sequencer_in_sync.sv | 41 ++++
 rtl/pipe_sequencer.sv | 177 +++++++++++++++++
 tb/tb_pipe_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: state encodings, retry limit
// and flush-counter width.
package pipe_ctrl_pkg;

   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
   localparam logic [STATE_W-1:0] ST_CFG      = 3'd1;
   localparam logic [STATE_W-1:0] ST_CFG_WAIT = 3'd2;
   localparam logic [STATE_W-1:0] ST_WAIT_SOF = 3'd3;
   localparam logic [STATE_W-1:0] ST_FLUSH    = 3'd4;
   localparam logic [STATE_W-1:0] ST_DRAIN    = 3'd5;
   localparam logic [STATE_W-1:0] ST_RUN      = 3'd6;
   localparam logic [STATE_W-1:0] ST_ERROR    = 3'd7;

   localparam int unsigned RETRY_LIMIT = 3;
   localparam int unsigned FLUSH_CNT_W = 8;

   typedef struct packed {
      logic mode;
      logic gaussian;
      logic sobel;
   } settings_t;

endpackage

// File: rtl/pipe_sequencer_in_sync.sv
// Two-flop synchronizer for one asynchronous level input, with an optional
// registered rising-edge strobe (EDGE_EN).
module in_sync #(
   parameter bit EDGE_EN = 1'b0
) (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q,
   output logic rise
);

   logic meta;
   logic sync;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= d;
         sync <= meta;
      end
   end

   assign q = sync;

   generate
      if (EDGE_EN) begin : g_edge
         logic prev;
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) prev <= 1'b0;
            else       prev <= sync;
         end
         assign rise = sync & ~prev;
      end else begin : g_no_edge
         assign rise = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/pipe_sequencer.sv
// Camera-config / pipeline-flush sequencer. Settings changes are applied only
// on a start-of-frame; define CFG_RETRY_EN to enable config timeout and retry.
module pipe_sequencer
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 16,
   parameter int unsigned CFG_TIMEOUT  = 125000000
) (
   input  logic i_sysclk,
   input  logic db_rstn,
   input  logic i_cfg_done,
   input  logic i_sof,
   input  logic i_pipe_empty,
   input  logic i_btn_mode,
   input  logic i_sw_gaussian,
   input  logic i_sw_sobel,
   output logic o_cfg_start,
   output logic o_mode,
   output logic o_gaussian_enable,
   output logic o_sobel_enable,
   output logic o_pipe_flush,
   output logic o_busy,
   output logic o_cfg_error
);

   logic [STATE_W-1:0]     state;
   logic [FLUSH_CNT_W-1:0] flush_cnt;
   settings_t              pending;
   settings_t              applied;
   logic                   cfg_frame;
   logic                   change_req;

   logic btn_rise;
   logic gaussian_sync;
   logic sobel_sync;
   logic btn_level;
   logic gaussian_rise;
   logic sobel_rise;
   logic unused_sync;

   in_sync #(.EDGE_EN(1'b1)) u_sync_btn (
      .clk (i_sysclk),
      .rstn(db_rstn),
      .d   (i_btn_mode),
      .q   (btn_level),
      .rise(btn_rise)
   );

   in_sync #(.EDGE_EN(1'b0)) u_sync_gaussian (
      .clk (i_sysclk),
      .rstn(db_rstn),
      .d   (i_sw_gaussian),
      .q   (gaussian_sync),
      .rise(gaussian_rise)
   );

   in_sync #(.EDGE_EN(1'b0)) u_sync_sobel (
      .clk (i_sysclk),
      .rstn(db_rstn),
      .d   (i_sw_sobel),
      .q   (sobel_sync),
      .rise(sobel_rise)
   );

   assign unused_sync = btn_level | gaussian_rise | sobel_rise;

   // Pending settings: switches track their synchronized level, mode toggles per press.
   always_ff @(posedge i_sysclk or negedge db_rstn) begin
      if (!db_rstn) begin
         pending <= '0;
      end else begin
         pending.gaussian <= gaussian_sync;
         pending.sobel    <= sobel_sync;
         if (btn_rise) pending.mode <= ~pending.mode;
      end
   end

   assign change_req = (pending != applied);

`ifdef CFG_RETRY_EN
   localparam int unsigned TO_W = (CFG_TIMEOUT > 1) ? $clog2(CFG_TIMEOUT) : 1;
   logic [TO_W-1:0] to_cnt;
   logic [1:0]      attempts;
   logic            cfg_err;
`else
   localparam int unsigned unused_cfg_timeout = CFG_TIMEOUT;
`endif

   always_ff @(posedge i_sysclk or negedge db_rstn) begin
      if (!db_rstn) begin
         state     <= ST_IDLE;
         flush_cnt <= '0;
         applied   <= '0;
         cfg_frame <= 1'b0;
`ifdef CFG_RETRY_EN
         to_cnt    <= '0;
         attempts  <= '0;
         cfg_err   <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: state <= ST_CFG;

            ST_CFG: begin
               state <= ST_CFG_WAIT;
`ifdef CFG_RETRY_EN
               to_cnt   <= '0;
               attempts <= attempts + 2'd1;
`endif
            end

            ST_CFG_WAIT: begin
               if (i_cfg_done) begin
                  state     <= ST_WAIT_SOF;
                  cfg_frame <= 1'b1;
`ifdef CFG_RETRY_EN
                  attempts  <= '0;
               end else if (to_cnt == TO_W'(CFG_TIMEOUT - 1)) begin
                  if (attempts >= 2'(RETRY_LIMIT)) begin
                     state   <= ST_ERROR;
                     cfg_err <= 1'b1;
                  end else begin
                     state <= ST_CFG;
                  end
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
`endif
               end
            end

            // A request withdrawn before its frame (e.g. two presses) returns to RUN;
            // the post-configuration frame always flushes.
            ST_WAIT_SOF: begin
               if (!cfg_frame && !change_req) begin
                  state <= ST_RUN;
               end else if (i_sof) begin
                  state     <= ST_FLUSH;
                  applied   <= pending;
                  cfg_frame <= 1'b0;
                  flush_cnt <= FLUSH_CNT_W'(FLUSH_CYCLES - 1);
               end
            end

            ST_FLUSH: begin
               if (flush_cnt == '0) state <= ST_DRAIN;
               else                 flush_cnt <= flush_cnt - FLUSH_CNT_W'(1);
            end

            ST_DRAIN: begin
               if (i_pipe_empty) state <= ST_RUN;
            end

            ST_RUN: begin
               if (change_req) state <= ST_WAIT_SOF;
            end

            ST_ERROR: state <= ST_ERROR;

            default: state <= ST_IDLE;
         endcase
      end
   end

   assign o_cfg_start       = (state == ST_CFG);
   assign o_pipe_flush      = (state == ST_FLUSH);
   assign o_busy            = (state != ST_RUN);
   assign o_mode            = applied.mode;
   assign o_gaussian_enable = applied.gaussian;
   assign o_sobel_enable    = applied.sobel;

`ifdef CFG_RETRY_EN
   assign o_cfg_error = cfg_err;
`else
   assign o_cfg_error = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed self-checking bench for pipe_sequencer (default build, or with
// CFG_RETRY_EN defined for the retry/timeout expectations).
module tb_pipe_sequencer;

   logic i_sysclk = 1'b0;
   logic db_rstn;
   logic i_cfg_done;
   logic i_sof;
   logic i_pipe_empty;
   logic i_btn_mode;
   logic i_sw_gaussian;
   logic i_sw_sobel;
   logic o_cfg_start;
   logic o_mode;
   logic o_gaussian_enable;
   logic o_sobel_enable;
   logic o_pipe_flush;
   logic o_busy;
   logic o_cfg_error;

   int errors = 0;
   int checks = 0;

   always #4 i_sysclk = ~i_sysclk;

   pipe_sequencer #(
      .FLUSH_CYCLES(16),
      .CFG_TIMEOUT (100)
   ) dut (
      .i_sysclk         (i_sysclk),
      .db_rstn          (db_rstn),
      .i_cfg_done       (i_cfg_done),
      .i_sof            (i_sof),
      .i_pipe_empty     (i_pipe_empty),
      .i_btn_mode       (i_btn_mode),
      .i_sw_gaussian    (i_sw_gaussian),
      .i_sw_sobel       (i_sw_sobel),
      .o_cfg_start      (o_cfg_start),
      .o_mode           (o_mode),
      .o_gaussian_enable(o_gaussian_enable),
      .o_sobel_enable   (o_sobel_enable),
      .o_pipe_flush     (o_pipe_flush),
      .o_busy           (o_busy),
      .o_cfg_error      (o_cfg_error)
   );

   task automatic tick();
      @(posedge i_sysclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Counts flush-high samples over a window that starts at the current sample.
   task automatic count_flush(output int n);
      n = int'(o_pipe_flush);
      for (int i = 1; i < 24; i++) begin
         tick();
         n += int'(o_pipe_flush);
      end
   endtask

   task automatic press_btn(input int hold, input int gap);
      i_btn_mode = 1'b1;
      repeat (hold) tick();
      i_btn_mode = 1'b0;
      repeat (gap) tick();
   endtask

   initial begin
      int n;
      int pulses;
      logic exp_start;

      db_rstn       = 1'b0;
      i_cfg_done    = 1'b0;
      i_sof         = 1'b0;
      i_pipe_empty  = 1'b0;
      i_btn_mode    = 1'b0;
      i_sw_gaussian = 1'b1;
      i_sw_sobel    = 1'b0;

      // Reset state: {start, mode, gauss, sobel, flush, busy, error}
      repeat (3) tick();
      check("reset_outputs",
            {25'd0, o_cfg_start, o_mode, o_gaussian_enable, o_sobel_enable,
             o_pipe_flush, o_busy, o_cfg_error}, 32'b0000010);

      // Bring-up: cfg_done seen at edge 51, sof at edge 101, pipe empty at edge 121
      db_rstn = 1'b1;
      for (int c = 1; c <= 125; c++) begin
         tick();
         check($sformatf("bringup_cfg_start_c%0d", c), 32'(o_cfg_start), 32'(c == 1));
         check($sformatf("bringup_flush_c%0d", c), 32'(o_pipe_flush),
               32'(c >= 101 && c <= 116));
         if (c == 100) check("gauss_before_sof", 32'(o_gaussian_enable), 32'd0);
         if (c == 101) check("gauss_after_sof", 32'(o_gaussian_enable), 32'd1);
         if (c == 101) check("sobel_after_sof", 32'(o_sobel_enable), 32'd0);
         if (c == 120) check("busy_in_drain", 32'(o_busy), 32'd1);
         if (c == 121) check("busy_run", 32'(o_busy), 32'd0);
         if (c == 50)  i_cfg_done   = 1'b1;
         if (c == 100) i_sof        = 1'b1;
         if (c == 101) i_sof        = 1'b0;
         if (c == 120) i_pipe_empty = 1'b1;
      end
      check("bringup_error", 32'(o_cfg_error), 32'd0);

      // Button press in RUN, frame ~200 cycles later
      press_btn(4, 4);
      repeat (192) tick();
      check("mode_wait_busy", 32'(o_busy), 32'd1);
      check("mode_before_sof", 32'(o_mode), 32'd0);
      i_sof = 1'b1;
      tick();
      i_sof = 1'b0;
      check("mode_at_sof_plus1", 32'(o_mode), 32'd1);
      check("mode_flush_first", 32'(o_pipe_flush), 32'd1);
      count_flush(n);
      check("mode_flush_len", 32'(n), 32'd16);
      check("mode_back_run", 32'(o_busy), 32'd0);

      // Two presses cancel: no flush, outputs unchanged, back in RUN
      press_btn(4, 4);
      press_btn(4, 12);
      check("cancel_run", 32'(o_busy), 32'd0);
      i_sof = 1'b1;
      tick();
      i_sof = 1'b0;
      count_flush(n);
      check("cancel_no_flush", 32'(n), 32'd0);
      check("cancel_outputs", {29'd0, o_mode, o_gaussian_enable, o_sobel_enable}, 32'b110);
      check("cancel_still_run", 32'(o_busy), 32'd0);

      // Sobel change, then gaussian toggled in the middle of that flush
      i_sw_sobel = 1'b1;
      repeat (6) tick();
      check("sobel_wait_busy", 32'(o_busy), 32'd1);
      i_sof = 1'b1;
      tick();
      i_sof = 1'b0;
      check("sobel_applied", {30'd0, o_gaussian_enable, o_sobel_enable}, 32'b11);
      n = int'(o_pipe_flush);
      for (int i = 1; i < 24; i++) begin
         tick();
         if (i == 4) i_sw_gaussian = 1'b0;
         n += int'(o_pipe_flush);
      end
      check("sobel_flush_len", 32'(n), 32'd16);
      check("gauss_second_wait", 32'(o_busy), 32'd1);
      check("gauss_not_yet", 32'(o_gaussian_enable), 32'd1);
      i_sof = 1'b1;
      tick();
      i_sof = 1'b0;
      check("gauss_at_sof_plus1", 32'(o_gaussian_enable), 32'd0);
      count_flush(n);
      check("gauss_flush_len", 32'(n), 32'd16);
      check("gauss_back_run", 32'(o_busy), 32'd0);

      // Reset asserted during the 5th flush cycle
      press_btn(4, 8);
      i_sof = 1'b1;
      tick();
      i_sof = 1'b0;
      repeat (4) tick();
      check("rst_flush_cycle5", 32'(o_pipe_flush), 32'd1);
      i_cfg_done = 1'b0;
      db_rstn    = 1'b0;
      #1;
      check("rst_flush_drop", 32'(o_pipe_flush), 32'd0);
      check("rst_outputs",
            {25'd0, o_cfg_start, o_mode, o_gaussian_enable, o_sobel_enable,
             o_pipe_flush, o_busy, o_cfg_error}, 32'b0000010);
      repeat (2) tick();
      db_rstn = 1'b1;

      // Restart with cfg_done held low
      pulses = 0;
      for (int c = 1; c <= 350; c++) begin
         tick();
`ifdef CFG_RETRY_EN
         exp_start = (c == 1) || (c == 102) || (c == 203);
`else
         exp_start = (c == 1);
`endif
         check($sformatf("restart_cfg_start_c%0d", c), 32'(o_cfg_start), 32'(exp_start));
         pulses += int'(o_cfg_start);
      end
`ifdef CFG_RETRY_EN
      check("retry_pulse_count", 32'(pulses), 32'd3);
      check("retry_cfg_error", 32'(o_cfg_error), 32'd1);
`else
      check("restart_pulse_count", 32'(pulses), 32'd1);
      check("no_retry_cfg_error", 32'(o_cfg_error), 32'd0);
`endif
      check("restart_busy", 32'(o_busy), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
